// File: rtl/inv_mat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inv_mat_pkg
// Description : Shared constants, augmented-row helper and handshake FSM
//               states for the matrix-inversion pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package inv_mat_pkg;

    localparam int               c_N       = 5;
    localparam int               c_DATA_W  = 32;
    localparam logic [31:0]      c_ONE_VAL = 32'h0001_0000;   // 1.0 in Q16.16

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int aug_row_len(input int n);
        return 2 * n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aug_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : aug_addr_gen
// Description : Row/column walker over the N x 2N augmented matrix; produces
//               the linear RAM address plus identity-half / diagonal flags.
// Revision    : 1.0 - initial release
// ============================================================================
module aug_addr_gen
    import inv_mat_pkg::*;
#(
    parameter int N         = c_N,
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_adv,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_is_identity_col,
    output logic              o_is_diag,
    output logic              o_is_last
);

    localparam int c_ROW_LEN = aug_row_len(N);
    localparam int c_COL_W   = $clog2(c_ROW_LEN);
    localparam int c_ROW_W   = (N > 1) ? $clog2(N) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(c_ROW_LEN - 1);
    localparam logic [c_COL_W-1:0] c_COL_N    = c_COL_W'(N);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(N - 1);

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [c_COL_W-1:0] w_ident_idx;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_adv) begin
            if (r_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign w_ident_idx       = r_col - c_COL_N;
    assign o_is_identity_col = (r_col >= c_COL_N);
    assign o_is_diag         = o_is_identity_col && (w_ident_idx == c_COL_W'(r_row));
    assign o_is_last         = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);

    // Legal parameters guarantee this sum fits in ADDR_W bits.
    assign o_addr = ADDR_W'(BASE_ADDR)
                  + ADDR_W'(r_row) * ADDR_W'(c_ROW_LEN)
                  + ADDR_W'(r_col);

endmodule
`default_nettype wire

// File: rtl/augmented_matrix_loader.sv
`default_nettype none
// ============================================================================
// Module      : augmented_matrix_loader
// Description : Streams a row-major N x N matrix A in and writes [A | I]
//               into the shared RAM, then pulses done to hand the RAM over.
// Revision    : 1.0 - initial release
// ============================================================================
module augmented_matrix_loader
    import inv_mat_pkg::*;
#(
    parameter int                N         = c_N,
    parameter int                DATA_W    = c_DATA_W,
    parameter int                ADDR_W    = 6,
    parameter logic [DATA_W-1:0] ONE_VAL   = c_ONE_VAL,
    parameter int                BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              busy,
    output logic              done
);

    generate
        if (N < 1 || BASE_ADDR < 0 ||
            BASE_ADDR + aug_row_len(N) * N > (1 << ADDR_W)) begin : g_param_check
            $error("augmented_matrix_loader: matrix does not fit in the RAM address space");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_ram_we;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [DATA_W-1:0]  r_ram_din;
    logic               r_busy;
    logic               r_done;

    logic               w_clr;
    logic               w_adv;
    logic               w_we_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [DATA_W-1:0]  w_din_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic [ADDR_W-1:0]  w_gen_addr;
    logic               w_is_identity_col;
    logic               w_is_diag;
    logic               w_is_last;

    aug_addr_gen #(
        .N         (N),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_gen (
        .clk               (clk),
        .rst               (rst),
        .i_clr             (w_clr),
        .i_adv             (w_adv),
        .o_addr            (w_gen_addr),
        .o_is_identity_col (w_is_identity_col),
        .o_is_diag         (w_is_diag),
        .o_is_last         (w_is_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_adv       = 1'b0;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_ram_addr;
        w_din_nxt   = r_ram_din;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = LOAD;
                    w_clr       = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            LOAD: begin
                // Identity half is self-generated; the A half waits on in_valid.
                if (w_is_identity_col) begin
                    w_adv      = 1'b1;
                    w_we_nxt   = 1'b1;
                    w_addr_nxt = w_gen_addr;
                    w_din_nxt  = w_is_diag ? ONE_VAL : '0;
                    if (w_is_last) begin
                        w_state_nxt = DONE;
                    end
                end else if (in_valid) begin
                    w_adv      = 1'b1;
                    w_we_nxt   = 1'b1;
                    w_addr_nxt = w_gen_addr;
                    w_din_nxt  = in_data;
                end
            end
            DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_ram_we   <= w_we_nxt;
            r_ram_addr <= w_addr_nxt;
            r_ram_din  <= w_din_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign in_ready = (r_state == LOAD) && !w_is_identity_col;
    assign ram_we   = r_ram_we;
    assign ram_addr = r_ram_addr;
    assign ram_din  = r_ram_din;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_augmented_matrix_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_augmented_matrix_loader
// Description : Self-checking bench; a position-based model of the [A | I]
//               write stream is checked cycle by cycle against the loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_augmented_matrix_loader;

    localparam int          N      = 5;
    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 6;
    localparam int          BASE   = 0;
    localparam int          ROWLEN = 2 * N;
    localparam int          TOTAL  = ROWLEN * N;
    localparam logic [31:0] ONE    = 32'h0001_0000;

    localparam int N2      = 2;
    localparam int BASE2   = 8;
    localparam int ADDR_W2 = 4;

    logic clk = 1'b0;
    logic rst, start, in_valid;
    logic [DATA_W-1:0] in_data;
    logic in_ready, ram_we, busy, done;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;

    logic start2, in_valid2;
    logic [DATA_W-1:0] in_data2;
    logic in_ready2, ram_we2, busy2, done2;
    logic [ADDR_W2-1:0] ram_addr2;
    logic [DATA_W-1:0] ram_din2;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    augmented_matrix_loader #(
        .N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ONE_VAL(ONE), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .busy(busy), .done(done)
    );

    augmented_matrix_loader #(
        .N(N2), .DATA_W(DATA_W), .ADDR_W(ADDR_W2), .ONE_VAL(ONE), .BASE_ADDR(BASE2)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_din(ram_din2),
        .busy(busy2), .done(done2)
    );

    always @(posedge clk) begin
        if (ram_we === 1'b1) mem[ram_addr] <= ram_din;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: in_valid high, A[r][c]=r*16+c; 1: in_valid toggles; 2: random.
    task automatic run_load(input int mode, input int restart_at, input int rst_at,
                            output int done_cyc);
        logic [DATA_W-1:0] a [0:N*N-1];
        logic [DATA_W-1:0] exp_din;
        logic [ADDR_W-1:0] exp_addr;
        int  k, p, stage, col, row;
        bit  exp_busy, gen, aborted, rst_now, exp_we;

        for (int i = 0; i < N*N; i++)
            a[i] = (mode == 0) ? DATA_W'((i / N) * 16 + (i % N)) : $urandom;
        k = 0; p = 0; stage = 0; exp_busy = 0; aborted = 0; done_cyc = -1;
        start = 1'b1; rst = 1'b0; in_valid = 1'b1; in_data = a[0];

        for (int cyc = 0; cyc < 400 && stage < 3 && !aborted; cyc++) begin
            rst_now = rst;
            gen = 0;
            col = p % ROWLEN;
            row = p / ROWLEN;
            if (exp_busy && p < TOTAL) begin
                chk("in_ready_load", in_ready, col < N);
                gen = (col < N) ? in_valid : 1'b1;
            end else begin
                chk("in_ready_idle", in_ready, 0);
            end
            exp_we   = gen && !rst_now;
            exp_addr = ADDR_W'(BASE + p);
            exp_din  = (col < N) ? in_data : ((col - N == row) ? ONE : '0);
            if (gen && col < N) k++;
            if (gen) begin
                p++;
                if (p == TOTAL) stage = 1;
            end
            if (start && !exp_busy) exp_busy = 1;
            if (stage > 0) stage++;
            if (stage == 3) exp_busy = 0;
            if (rst_now) begin
                exp_busy = 0;
                stage    = 0;
                aborted  = 1;
            end

            step();
            chk("ram_we", ram_we, exp_we);
            if (exp_we) begin
                chk("ram_addr", ram_addr, exp_addr);
                chk("ram_din", ram_din, exp_din);
            end
            chk("done", done, stage == 3);
            chk("busy", busy, exp_busy);
            if (done === 1'b1) done_cyc = cyc + 1;
            if (aborted) chk("in_ready_after_rst", in_ready, 0);

            start    = (cyc + 1 == restart_at);
            rst      = (cyc + 1 == rst_at);
            in_valid = (mode == 0) ? 1'b1 :
                       (mode == 1) ? ((cyc + 1) % 2 == 1) : 1'($urandom % 2);
            in_data  = (k < N*N) ? a[k] : $urandom;
        end
        if (stage < 3 && !aborted) chk("load_timeout", 0, 1);
        start = 1'b0; rst = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        int dc;
        logic [DATA_W-1:0] b [0:3];
        logic [DATA_W-1:0] exp2 [0:7];
        int widx, k2, done2_cyc;
        bit hs;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        start2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0;
        step(); step(); step();
        rst = 1'b0;
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ram_we2", ram_we2, 0);
        chk("rst_done2", done2, 0);

        run_load(0, -1, -1, dc);
        chk("done_cycle_full", dc, 52);
        for (int i = 0; i < N; i++) chk("mem_a_row0", mem[i], i);
        chk("mem5_one", mem[5], ONE);
        for (int i = 6; i < 10; i++) chk("mem_ident_zero", mem[i], 0);
        chk("mem10_a10", mem[10], 32'h10);
        chk("mem16_one", mem[16], ONE);
        chk("mem49_one", mem[49], ONE);

        run_load(1, -1, -1, dc);
        run_load(0, 20, -1, dc);
        chk("done_cycle_restart", dc, 52);
        run_load(2, -1, 30, dc);
        chk("no_done_on_rst", dc, -1);
        run_load(2, -1, -1, dc);

        // Second instance: N=2 at BASE_ADDR=8
        for (int i = 0; i < 4; i++) b[i] = $urandom;
        exp2[0] = b[0]; exp2[1] = b[1]; exp2[2] = ONE; exp2[3] = '0;
        exp2[4] = b[2]; exp2[5] = b[3]; exp2[6] = '0;  exp2[7] = ONE;
        widx = 0; k2 = 0; done2_cyc = -1;
        start2 = 1'b1; in_valid2 = 1'b1; in_data2 = b[0];
        for (int cyc = 0; cyc < 16; cyc++) begin
            hs = (in_ready2 === 1'b1) && in_valid2;
            step();
            start2 = 1'b0;
            if (hs) k2++;
            chk("n2_ram_we", ram_we2, (cyc + 1 >= 2) && (cyc + 1 <= 9));
            if (ram_we2 === 1'b1 && widx < 8) begin
                chk("n2_ram_addr", ram_addr2, BASE2 + widx);
                chk("n2_ram_din", ram_din2, exp2[widx]);
                widx++;
            end
            chk("n2_done", done2, cyc + 1 == 10);
            if (done2 === 1'b1) done2_cyc = cyc + 1;
            in_data2 = (k2 < 4) ? b[k2] : '0;
        end
        chk("n2_write_count", widx, 8);
        chk("n2_done_cycle", done2_cyc, 10);
        in_valid2 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/augmented_matrix_loader.md
Name: augmented_matrix_loader

Overview:
Upstream feeder for the matrix-inversion stage. It accepts the N x N source matrix A as a valid/ready stream of elements in row-major order. It builds the N x 2N augmented matrix [A | I] and writes it into the shared single-port RAM, one word per cycle, in the row-major layout the inversion stage reads (row r occupies addresses BASE_ADDR + r*2N .. + 2N-1). Asserting done hands the RAM over to the inversion stage.

Parameters:
N, 5, matrix order; augmented row length is 2N
DATA_W, 32, element width (Q16.16 fixed point)
ADDR_W, 6, RAM address width; must satisfy 2^ADDR_W >= BASE_ADDR + 2N*N
ONE_VAL, 32'h0001_0000, identity diagonal value (1.0 in Q16.16)
BASE_ADDR, 0, RAM address of element [0][0]

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse that begins a load; sampled only in IDLE
in_data  in  DATA_W  source matrix element A[r][c]
in_valid  in  1  in_data valid
in_ready  out  1  element accepted when in_valid && in_ready
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_din  out  DATA_W  RAM write data
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse after the last RAM write is issued

Behaviour:
- Reset values: state=IDLE, row=0, col=0, ram_we=0, ram_addr=0, ram_din=0, busy=0, done=0. in_ready=0.
- FSM states and transitions:
  - IDLE: start=1 -> LOAD, with row=0, col=0, busy=1. Any other input is ignored.
  - LOAD, col<N (A half): in_ready=1.
    - On handshake, the next cycle drives ram_we=1, ram_addr=BASE_ADDR+row*2N+col, ram_din=in_data, and col advances.
    - No handshake: ram_we=0 next cycle and the counters hold. Stalls of any length are legal.
  - LOAD, col>=N (identity half): in_ready=0, with no handshake needed.
    - Every cycle issues one write with ram_din = (col-N==row) ? ONE_VAL : 0.
    - col advances by 1.
  - Column wrap: at col=2N-1, col->0 and row->row+1. The write for (N-1, 2N-1) moves the FSM to DONE.
  - DONE: ram_we=0, done=1 for exactly one cycle, busy->0, then IDLE.
- All RAM-side outputs are registered, so a write lands one cycle after acceptance or generation. in_ready is decoded from the state and column registers only; there is no combinational path from in_valid.
- Latency: with in_valid held high, start at cycle 0 gives the first write at cycle 2, the last (50th for N=5) at cycle 51, and done at cycle 52.
- Address arithmetic: row*2N+col is computed at ADDR_W bits and never wraps for legal parameters. Illegal parameters are rejected by an elaboration-time check.
- start while busy: ignored; it neither restarts nor queues.
- in_valid outside LOAD or in the identity half: ignored, with no acceptance.
- rst mid-load:
  - Next cycle returns to IDLE with ram_we=0.
  - RAM keeps any partial contents.
  - done is not pulsed.
- Outputs never carry X after reset.

Decomposition:
- Shared package inv_mat_pkg holds:
  - DATA_W, the Q16.16 constant ONE_VAL, N;
  - the augmented row-length function 2N;
  - the FSM state enum {IDLE, LOAD, DONE}, which the inversion stage reuses for its own handshake.
- One sub-module is natural: aug_addr_gen, holding the row/col counters with wrap, the linear address, and the is_identity_col/is_diag flags.
- The FSM and output registers stay in the top module.

Test Plan:
- Full load, N=5, A[r][c]=r*16+c with in_valid always high, start at cycle 0 -> 50 writes at cycles 2..51:
  - addr 0..4 = 0,1,2,3,4; addr 5 = 0x10000 and addr 6..9 = 0;
  - addr 16 = 0x10000; addr 49 = 0x10000;
  - done high only at cycle 52.
- Backpressure: in_valid toggles 1,0,1,0 -> no ram_we on stall cycles, and addresses stay contiguous.
- Identity half timing: in_ready=0 for 5 consecutive cycles per row, with writes issued even when in_valid=0.
- start pulsed again at cycle 20 of a load -> no effect; done still fires once, at the original time.
- rst asserted at cycle 30 -> at cycle 31: ram_we=0, busy=0, in_ready=0. A new start then reloads from addr 0.
- BASE_ADDR=8, N=2 -> writes land at 8..15 as [a00 a01 1.0 0 a10 a11 0 1.0]; done follows the 8th write.
